// File: rtl/riscv_pkg.sv
// Shared definitions for the ALU issue path: datapath widths, ALU op encodings
// and the reservation-station entry layout.
package riscv_pkg;

  localparam int REG_SIZE      = 32;
  localparam int NUM_TAGS      = 64;
  localparam int NUM_TAGS_LOG2 = $clog2(NUM_TAGS);
  localparam int ROB_SIZE      = 64;
  localparam int ROB_SIZE_LOG2 = $clog2(ROB_SIZE);
  localparam int OP_W          = 4;

  localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [OP_W-1:0] ALU_XOR = 4'd2;
  localparam logic [OP_W-1:0] ALU_AND = 4'd3;
  localparam logic [OP_W-1:0] ALU_SLL = 4'd4;
  localparam logic [OP_W-1:0] ALU_SRL = 4'd5;
  localparam logic [OP_W-1:0] ALU_SRA = 4'd6;

  typedef logic [REG_SIZE-1:0]      word_t;
  typedef logic [NUM_TAGS_LOG2-1:0] tag_t;
  typedef logic [ROB_SIZE_LOG2-1:0] rob_idx_t;

  typedef struct packed {
    word_t val;
    tag_t  tag;
    logic  rdy;
  } rs_src_t;

  typedef struct packed {
    logic            valid;
    logic [OP_W-1:0] op;
    rs_src_t         src1;
    rs_src_t         src2;
    tag_t            rd_tag;
    rob_idx_t        rob_index;
  } rs_entry_t;

  // A source still waiting on its producer matches a broadcast of that tag.
  function automatic logic src_hit(input rs_src_t src, input tag_t tag);
    return !src.rdy && (src.tag == tag);
  endfunction

endpackage

// File: rtl/age_matrix_picker.sv
// Oldest-first multi-grant picker. age_q[i][j] = 1 means entry i was allocated
// before entry j; grant k is the oldest eligible entry not taken by grants 0..k-1.
module age_matrix_picker #(
  parameter int RS_SIZE = 8,
  parameter int NUM_FU  = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic [RS_SIZE-1:0]              elig_i,
  input  logic [RS_SIZE-1:0]              alloc_i,
  input  logic [RS_SIZE-1:0]              free_i,
  output logic [NUM_FU-1:0][RS_SIZE-1:0]  grant_o
);

  logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q;
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age_d;
  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_than_s;
  logic [NUM_FU-1:0][RS_SIZE-1:0]  grant_s;
  logic [RS_SIZE-1:0]              remain_s;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        older_than_s[i][j] = age_q[j][i];
      end
    end
  end

  // An entry wins a round when no other remaining candidate is older than it.
  always_comb begin
    grant_s  = '0;
    remain_s = elig_i;
    for (int k = 0; k < NUM_FU; k++) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (remain_s[i] && ((remain_s & older_than_s[i]) == '0)) begin
          grant_s[k][i] = 1'b1;
        end else begin
          grant_s[k][i] = 1'b0;
        end
      end
      remain_s = remain_s & ~grant_s[k];
    end
  end

  assign grant_o = grant_s;

  // A new entry is younger than everyone: clear its row, set its column.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      for (int j = 0; j < RS_SIZE; j++) begin
        if (alloc_i[i] || free_i[i]) begin
          age_d[i][j] = 1'b0;
        end else if (alloc_i[j]) begin
          age_d[i][j] = 1'b1;
        end else begin
          age_d[i][j] = age_q[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Reservation station for single-cycle ALUs: captures operands off the wakeup
// buses and issues up to NUM_FU ready ops per cycle, oldest first, registered.
module alu_issue_scheduler
  import riscv_pkg::*;
#(
  parameter int RS_SIZE = 8,
  parameter int NUM_FU  = 2,
  parameter int NUM_WB  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              disp_valid,
  output logic                              disp_ready,
  input  logic [OP_W-1:0]                   disp_op,
  input  logic [REG_SIZE-1:0]               disp_src1_val,
  input  logic [NUM_TAGS_LOG2-1:0]          disp_src1_tag,
  input  logic                              disp_src1_rdy,
  input  logic [REG_SIZE-1:0]               disp_src2_val,
  input  logic [NUM_TAGS_LOG2-1:0]          disp_src2_tag,
  input  logic                              disp_src2_rdy,
  input  logic [NUM_TAGS_LOG2-1:0]          disp_rd_tag,
  input  logic [ROB_SIZE_LOG2-1:0]          disp_rob_index,
  input  logic [NUM_WB-1:0]                 wb_valid,
  input  logic [NUM_WB*NUM_TAGS_LOG2-1:0]   wb_tag,
  input  logic [NUM_WB*REG_SIZE-1:0]        wb_data,
  output logic [NUM_FU-1:0]                 fu_valid,
  output logic [NUM_FU*OP_W-1:0]            fu_op,
  output logic [NUM_FU*REG_SIZE-1:0]        fu_rs1,
  output logic [NUM_FU*REG_SIZE-1:0]        fu_rs2,
  output logic [NUM_FU*NUM_TAGS_LOG2-1:0]   fu_tag,
  output logic [NUM_FU*ROB_SIZE_LOG2-1:0]   fu_rob_index
);

  localparam int RS_SIZE_LOG2 = $clog2(RS_SIZE);

  // Lowest-numbered matching bus wins, so scan from the top down.
  function automatic rs_src_t wake_src(
    input rs_src_t                            src,
    input logic [NUM_WB-1:0]                  v,
    input logic [NUM_WB*NUM_TAGS_LOG2-1:0]    tags,
    input logic [NUM_WB*REG_SIZE-1:0]         data
  );
    rs_src_t res;
    res = src;
    for (int b = NUM_WB - 1; b >= 0; b--) begin
      if (v[b] && src_hit(src, tags[b*NUM_TAGS_LOG2 +: NUM_TAGS_LOG2])) begin
        res.val = data[b*REG_SIZE +: REG_SIZE];
        res.rdy = 1'b1;
      end
    end
    return res;
  endfunction

  rs_entry_t                       entries_q [RS_SIZE];
  rs_entry_t                       entries_d [RS_SIZE];
  rs_entry_t                       new_entry_s;
  logic [RS_SIZE-1:0]              valid_s;
  logic [RS_SIZE-1:0]              elig_s;
  logic [RS_SIZE-1:0]              alloc_s;
  logic [RS_SIZE-1:0]              issue_s;
  logic [NUM_FU-1:0][RS_SIZE-1:0]  grant_s;
  logic [RS_SIZE_LOG2-1:0]         free_idx_s;
  logic                            free_found_s;
  logic                            disp_fire_s;

  logic [NUM_FU-1:0]               fu_valid_q, fu_valid_d;
  logic [NUM_FU*OP_W-1:0]          fu_op_q, fu_op_d;
  logic [NUM_FU*REG_SIZE-1:0]      fu_rs1_q, fu_rs1_d;
  logic [NUM_FU*REG_SIZE-1:0]      fu_rs2_q, fu_rs2_d;
  logic [NUM_FU*NUM_TAGS_LOG2-1:0] fu_tag_q, fu_tag_d;
  logic [NUM_FU*ROB_SIZE_LOG2-1:0] fu_rob_q, fu_rob_d;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_s[i] = entries_q[i].valid;
      elig_s[i]  = entries_q[i].valid && entries_q[i].src1.rdy && entries_q[i].src2.rdy;
    end
  end

  // Occupancy comes from registered valids only, so slots freed by this
  // cycle's issue cannot be refilled until the next cycle.
  assign disp_ready  = !rst && !(&valid_s);
  assign disp_fire_s = disp_valid && disp_ready && !flush;

  always_comb begin
    free_idx_s   = '0;
    free_found_s = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!valid_s[i] && !free_found_s) begin
        free_idx_s   = RS_SIZE_LOG2'(i);
        free_found_s = 1'b1;
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  always_comb begin
    alloc_s = '0;
    if (disp_fire_s) begin
      alloc_s[free_idx_s] = 1'b1;
    end else begin
      alloc_s = '0;
    end
  end

  always_comb begin
    issue_s = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      issue_s = issue_s | grant_s[k];
    end
  end

  age_matrix_picker #(
    .RS_SIZE (RS_SIZE),
    .NUM_FU  (NUM_FU)
  ) u_picker (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .elig_i  (elig_s),
    .alloc_i (alloc_s),
    .free_i  (issue_s),
    .grant_o (grant_s)
  );

  // Dispatching op, with same-cycle wakeup bypass applied to waiting sources.
  always_comb begin
    new_entry_s.valid     = 1'b1;
    new_entry_s.op        = disp_op;
    new_entry_s.src1.val  = disp_src1_val;
    new_entry_s.src1.tag  = disp_src1_tag;
    new_entry_s.src1.rdy  = disp_src1_rdy;
    new_entry_s.src2.val  = disp_src2_val;
    new_entry_s.src2.tag  = disp_src2_tag;
    new_entry_s.src2.rdy  = disp_src2_rdy;
    new_entry_s.rd_tag    = disp_rd_tag;
    new_entry_s.rob_index = disp_rob_index;
    new_entry_s.src1      = wake_src(new_entry_s.src1, wb_valid, wb_tag, wb_data);
    new_entry_s.src2      = wake_src(new_entry_s.src2, wb_valid, wb_tag, wb_data);
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        entries_d[i].src1 = wake_src(entries_q[i].src1, wb_valid, wb_tag, wb_data);
        entries_d[i].src2 = wake_src(entries_q[i].src2, wb_valid, wb_tag, wb_data);
      end else begin
        entries_d[i] = entries_q[i];
      end
      if (issue_s[i] || flush) begin
        entries_d[i].valid = 1'b0;
      end else begin
        entries_d[i].valid = entries_q[i].valid;
      end
    end
    if (disp_fire_s) begin
      entries_d[free_idx_s] = new_entry_s;
    end else begin
      entries_d[free_idx_s] = entries_d[free_idx_s];
    end
  end

  // Grants are one-hot per port, so OR-ing selected fields leaves idle ports at zero.
  always_comb begin
    fu_valid_d = '0;
    fu_op_d    = '0;
    fu_rs1_d   = '0;
    fu_rs2_d   = '0;
    fu_tag_d   = '0;
    fu_rob_d   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (grant_s[k][i]) begin
          fu_valid_d[k]                                   = 1'b1;
          fu_op_d[k*OP_W +: OP_W]                         = entries_q[i].op;
          fu_rs1_d[k*REG_SIZE +: REG_SIZE]                = entries_q[i].src1.val;
          fu_rs2_d[k*REG_SIZE +: REG_SIZE]                = entries_q[i].src2.val;
          fu_tag_d[k*NUM_TAGS_LOG2 +: NUM_TAGS_LOG2]      = entries_q[i].rd_tag;
          fu_rob_d[k*ROB_SIZE_LOG2 +: ROB_SIZE_LOG2]      = entries_q[i].rob_index;
        end else begin
          fu_valid_d[k] = fu_valid_d[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      fu_valid_q <= '0;
      fu_op_q    <= '0;
      fu_rs1_q   <= '0;
      fu_rs2_q   <= '0;
      fu_tag_q   <= '0;
      fu_rob_q   <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
      if (flush) begin
        fu_valid_q <= '0;
        fu_op_q    <= '0;
        fu_rs1_q   <= '0;
        fu_rs2_q   <= '0;
        fu_tag_q   <= '0;
        fu_rob_q   <= '0;
      end else begin
        fu_valid_q <= fu_valid_d;
        fu_op_q    <= fu_op_d;
        fu_rs1_q   <= fu_rs1_d;
        fu_rs2_q   <= fu_rs2_d;
        fu_tag_q   <= fu_tag_d;
        fu_rob_q   <= fu_rob_d;
      end
    end
  end

  assign fu_valid     = fu_valid_q;
  assign fu_op        = fu_op_q;
  assign fu_rs1       = fu_rs1_q;
  assign fu_rs2       = fu_rs2_q;
  assign fu_tag       = fu_tag_q;
  assign fu_rob_index = fu_rob_q;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: ordered-queue reference model checked every
// cycle, directed scenarios pinned with literal values, then random traffic.
module tb_alu_issue_scheduler;
  import riscv_pkg::*;

  localparam int NFU = 2;
  localparam int NWB = 2;
  localparam int RS  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, flush, disp_valid, disp_ready;
  logic [3:0]      disp_op;
  logic [31:0]     disp_src1_val, disp_src2_val;
  logic [5:0]      disp_src1_tag, disp_src2_tag, disp_rd_tag, disp_rob_index;
  logic            disp_src1_rdy, disp_src2_rdy;
  logic [NWB-1:0]  wb_valid;
  logic [NWB*6-1:0]  wb_tag;
  logic [NWB*32-1:0] wb_data;
  logic [NFU-1:0]    fu_valid;
  logic [NFU*4-1:0]  fu_op;
  logic [NFU*32-1:0] fu_rs1, fu_rs2;
  logic [NFU*6-1:0]  fu_tag, fu_rob_index;

  alu_issue_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_src1_val(disp_src1_val), .disp_src1_tag(disp_src1_tag), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_val(disp_src2_val), .disp_src2_tag(disp_src2_tag), .disp_src2_rdy(disp_src2_rdy),
    .disp_rd_tag(disp_rd_tag), .disp_rob_index(disp_rob_index),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .fu_valid(fu_valid), .fu_op(fu_op), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2),
    .fu_tag(fu_tag), .fu_rob_index(fu_rob_index)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] v1, v2;
    logic [5:0]  t1, t2;
    logic        r1, r2;
    logic [5:0]  rd, rob;
  } ment_t;

  ment_t          mq[$];          // pending ops, oldest at the front
  ment_t          exp_fu [NFU];
  logic [NFU-1:0] exp_valid;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ment_t wake_m(input ment_t e);
    for (int b = 0; b < NWB; b++) begin
      if (wb_valid[b]) begin
        if (!e.r1 && e.t1 == wb_tag[b*6 +: 6]) begin e.v1 = wb_data[b*32 +: 32]; e.r1 = 1'b1; end
        if (!e.r2 && e.t2 == wb_tag[b*6 +: 6]) begin e.v2 = wb_data[b*32 +: 32]; e.r2 = 1'b1; end
      end
    end
    return e;
  endfunction

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    ment_t e;
    bit    acc;
    int    i, n;
    acc = !rst && (mq.size() < RS) && disp_valid;
    exp_valid = '0;
    for (int k = 0; k < NFU; k++) exp_fu[k] = '{default: '0};
    if (rst || flush) begin
      mq.delete();
      return;
    end
    i = 0; n = 0;
    while (i < mq.size()) begin
      if (n < NFU && mq[i].r1 && mq[i].r2) begin
        exp_fu[n] = mq[i]; exp_valid[n] = 1'b1; n++; mq.delete(i);
      end else begin
        i++;
      end
    end
    for (int j = 0; j < mq.size(); j++) mq[j] = wake_m(mq[j]);
    if (acc) begin
      e.op = disp_op; e.v1 = disp_src1_val; e.t1 = disp_src1_tag; e.r1 = disp_src1_rdy;
      e.v2 = disp_src2_val; e.t2 = disp_src2_tag; e.r2 = disp_src2_rdy;
      e.rd = disp_rd_tag; e.rob = disp_rob_index;
      mq.push_back(wake_m(e));
    end
  endtask

  task automatic compare();
    chk("disp_ready", disp_ready, 64'(!rst && (mq.size() < RS)));
    for (int k = 0; k < NFU; k++) begin
      chk($sformatf("fu%0d_valid", k), fu_valid[k], exp_valid[k]);
      chk($sformatf("fu%0d_op", k), fu_op[k*4 +: 4], exp_fu[k].op);
      chk($sformatf("fu%0d_rs1", k), fu_rs1[k*32 +: 32], exp_fu[k].v1);
      chk($sformatf("fu%0d_rs2", k), fu_rs2[k*32 +: 32], exp_fu[k].v2);
      chk($sformatf("fu%0d_tag", k), fu_tag[k*6 +: 6], exp_fu[k].rd);
      chk($sformatf("fu%0d_rob", k), fu_rob_index[k*6 +: 6], exp_fu[k].rob);
    end
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    #1;
    compare();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_op = 4'd0;
    disp_src1_val = 32'd0; disp_src1_tag = 6'd0; disp_src1_rdy = 1'b0;
    disp_src2_val = 32'd0; disp_src2_tag = 6'd0; disp_src2_rdy = 1'b0;
    disp_rd_tag = 6'd0; disp_rob_index = 6'd0;
    wb_valid = '0; wb_tag = '0; wb_data = '0;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [31:0] v1, input logic [5:0] t1,
                          input logic r1, input logic [31:0] v2, input logic [5:0] t2,
                          input logic r2, input logic [5:0] rd, input logic [5:0] rob);
    disp_valid = 1'b1; disp_op = op;
    disp_src1_val = v1; disp_src1_tag = t1; disp_src1_rdy = r1;
    disp_src2_val = v2; disp_src2_tag = t2; disp_src2_rdy = r2;
    disp_rd_tag = rd; disp_rob_index = rob;
  endtask

  task automatic wake(input int bus, input logic [5:0] tag, input logic [31:0] data);
    wb_valid[bus] = 1'b1;
    wb_tag[bus*6 +: 6] = tag;
    wb_data[bus*32 +: 32] = data;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    exp_valid = '0;
    for (int k = 0; k < NFU; k++) exp_fu[k] = '{default: '0};
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset behaviour
    chk("rst_ready_low", disp_ready, 1'b0);
    tick();
    idle();
    #1;
    chk("ready_after_rst", disp_ready, 1'b1);
    chk("rst_fu_valid", fu_valid, 2'b00);

    // 1: ready ADD issues one cycle after dispatch
    set_disp(ALU_ADD, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 6'd3, 6'd1);
    tick();
    chk("t1_not_yet", fu_valid, 2'b00);
    idle(); tick();
    chk("t1_valid", fu_valid, 2'b01);
    chk("t1_op", fu_op[3:0], 4'b0000);
    chk("t1_rs1", fu_rs1[31:0], 32'd5);
    chk("t1_rs2", fu_rs2[31:0], 32'd7);
    chk("t1_tag", fu_tag[5:0], 6'd3);
    chk("t1_model", exp_valid, 2'b01);
    idle(); tick();
    chk("t1_idle", fu_valid, 2'b00);

    // 2: wakeup on bus 1 two cycles after dispatch
    set_disp(ALU_SUB, 32'd0, 6'd9, 1'b0, 32'd2, 6'd0, 1'b1, 6'd4, 6'd2);
    tick();
    idle(); tick();
    idle(); wake(1, 6'd9, 32'h1234); tick();
    chk("t2_wait", fu_valid, 2'b00);
    idle(); tick();
    chk("t2_valid", fu_valid, 2'b01);
    chk("t2_rs1", fu_rs1[31:0], 32'h1234);
    chk("t2_model_rs1", exp_fu[0].v1, 32'h1234);

    // 3: fill the queue, wake two entries together
    for (int i = 0; i < RS; i++) begin
      idle();
      set_disp(ALU_XOR, 32'd0, (i == 2 || i == 5) ? 6'd20 : 6'd30, 1'b0,
               32'(i), 6'd0, 1'b1, 6'(i + 8), 6'(i));
      tick();
    end
    idle(); set_disp(ALU_XOR, 32'd0, 6'd30, 1'b0, 32'd9, 6'd0, 1'b1, 6'd16, 6'd8);
    #1;
    chk("t3_full", disp_ready, 1'b0);
    tick();
    idle(); set_disp(ALU_XOR, 32'd0, 6'd30, 1'b0, 32'd9, 6'd0, 1'b1, 6'd16, 6'd8);
    wake(0, 6'd20, 32'h55);
    tick();
    chk("t3_woken_not_issued", fu_valid, 2'b00);
    idle(); set_disp(ALU_XOR, 32'd0, 6'd30, 1'b0, 32'd9, 6'd0, 1'b1, 6'd16, 6'd8);
    tick();
    chk("t3_both", fu_valid, 2'b11);
    chk("t3_port0_rob", fu_rob_index[5:0], 6'd2);
    chk("t3_port1_rob", fu_rob_index[11:6], 6'd5);
    chk("t3_port1_rs1", fu_rs1[63:32], 32'h55);
    idle(); set_disp(ALU_XOR, 32'd0, 6'd30, 1'b0, 32'd9, 6'd0, 1'b1, 6'd16, 6'd8);
    #1;
    chk("t3_ready_again", disp_ready, 1'b1);
    tick();
    idle(); wake(0, 6'd30, 32'h77); tick();
    for (int i = 0; i < 5; i++) begin idle(); tick(); end
    chk("t3_drained", 64'(mq.size()), 64'd0);

    // 4: younger ready ops overtake an older waiting op
    idle(); set_disp(ALU_AND, 32'd0, 6'd40, 1'b0, 32'd1, 6'd0, 1'b1, 6'd10, 6'd10); tick();
    idle(); set_disp(ALU_AND, 32'd3, 6'd0, 1'b1, 32'd0, 6'd41, 1'b0, 6'd11, 6'd11); tick();
    idle(); set_disp(ALU_AND, 32'd3, 6'd0, 1'b1, 32'd0, 6'd41, 1'b0, 6'd12, 6'd12); tick();
    idle(); wake(0, 6'd41, 32'h9); tick();
    idle(); tick();
    chk("t4_bc_valid", fu_valid, 2'b11);
    chk("t4_port0_b", fu_rob_index[5:0], 6'd11);
    chk("t4_port1_c", fu_rob_index[11:6], 6'd12);
    idle(); wake(1, 6'd40, 32'h3); tick();
    idle(); tick();
    chk("t4_a_valid", fu_valid, 2'b01);
    chk("t4_a_rob", fu_rob_index[5:0], 6'd10);

    // 5: wakeup bypass on the dispatch cycle
    idle(); set_disp(ALU_SLL, 32'd0, 6'd50, 1'b0, 32'd4, 6'd0, 1'b1, 6'd13, 6'd13);
    wake(0, 6'd50, 32'hABCD);
    tick();
    chk("t5_not_yet", fu_valid, 2'b00);
    idle(); tick();
    chk("t5_valid", fu_valid, 2'b01);
    chk("t5_rs1", fu_rs1[31:0], 32'hABCD);

    // 6: flush with occupied entries and a concurrent dispatch, then reset
    for (int i = 0; i < 5; i++) begin
      idle(); set_disp(ALU_SRL, 32'd0, 6'd60, 1'b0, 32'd1, 6'd0, 1'b1, 6'(i), 6'(20 + i)); tick();
    end
    idle(); flush = 1'b1;
    set_disp(ALU_ADD, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 6'd7, 6'd30);
    tick();
    chk("t6_flush_fu", fu_valid, 2'b00);
    chk("t6_model_empty", 64'(mq.size()), 64'd0);
    idle(); wake(0, 6'd60, 32'd1); tick();
    for (int i = 0; i < 2; i++) begin
      idle(); tick();
      chk("t6_no_issue", fu_valid, 2'b00);
    end
    for (int i = 0; i < 3; i++) begin
      idle(); set_disp(ALU_SRA, 32'd0, 6'd61, 1'b0, 32'd1, 6'd0, 1'b1, 6'(i), 6'(40 + i)); tick();
    end
    idle(); rst = 1'b1; wake(0, 6'd61, 32'd2);
    #1;
    chk("t6_rst_ready", disp_ready, 1'b0);
    tick();
    idle(); rst = 1'b1; tick();
    idle(); wake(0, 6'd61, 32'd2); tick();
    chk("t6_rst_fu0", fu_valid, 2'b00);
    idle(); tick();
    chk("t6_rst_fu1", fu_valid, 2'b00);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 7)
        set_disp(4'($urandom_range(0, 6)), $urandom, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 6'($urandom), 6'($urandom));
      for (int b = 0; b < NWB; b++)
        if ($urandom_range(0, 1) == 1) wake(b, 6'($urandom_range(0, 7)), $urandom);
      if (wb_valid == 2'b11 && wb_tag[5:0] == wb_tag[11:6]) wb_data[63:32] = wb_data[31:0];
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
